// File: rtl/uart_boot_ctrl_if.sv
// Host-side and register-side bus bundle for uart_boot_ctrl.
// The controller connects through the slave modport; the bench (host + register model) through master.
interface uart_boot_ctrl_if #(
  parameter int MEM_SIZE   = 6,
  parameter int DATA_WIDTH = 32
);
  logic                    h_we_i, h_re_i;
  logic [MEM_SIZE-1:0]     h_waddr_i, h_raddr_i;
  logic [DATA_WIDTH-1:0]   h_wdata_i;
  logic [DATA_WIDTH/8-1:0] h_wstrb_i;
  logic [1:0]              h_wresp_o, h_rresp_o;
  logic [DATA_WIDTH-1:0]   h_rdata_o;

  logic                    mem_we_o, mem_re_o;
  logic [MEM_SIZE-1:0]     mem_waddr_o, mem_raddr_o;
  logic [DATA_WIDTH-1:0]   mem_wdata_o;
  logic [DATA_WIDTH/8-1:0] mem_wstrb_o;
  logic [1:0]              mem_wresp_i, mem_rresp_i;
  logic [DATA_WIDTH-1:0]   mem_rdata_i;

  modport slave (
    input  h_we_i, h_re_i, h_waddr_i, h_raddr_i, h_wdata_i, h_wstrb_i,
    output h_wresp_o, h_rresp_o, h_rdata_o,
    output mem_we_o, mem_re_o, mem_waddr_o, mem_raddr_o, mem_wdata_o, mem_wstrb_o,
    input  mem_wresp_i, mem_rresp_i, mem_rdata_i
  );

  modport master (
    output h_we_i, h_re_i, h_waddr_i, h_raddr_i, h_wdata_i, h_wstrb_i,
    input  h_wresp_o, h_rresp_o, h_rdata_o,
    input  mem_we_o, mem_re_o, mem_waddr_o, mem_raddr_o, mem_wdata_o, mem_wstrb_o,
    output mem_wresp_i, mem_rresp_i, mem_rdata_i
  );
endinterface

// File: rtl/uart_boot_ctrl.sv
// UART boot sequencer: programs CLK_DIV/CFG/CTRL after reset, then hands the register port to the host.
// Optional readback of CLK_DIV is enabled by defining UART_BOOT_VERIFY_EN.
module uart_boot_ctrl #(
  parameter int                    MEM_SIZE     = 6,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    START_DELAY  = 16,
  parameter int                    MAX_RETRY    = 3,
  parameter logic [MEM_SIZE-1:0]   CTRL_ADDR    = 'h00,
  parameter logic [MEM_SIZE-1:0]   CFG_ADDR     = 'h04,
  parameter logic [MEM_SIZE-1:0]   CLK_DIV_ADDR = 'h08,
  parameter logic [DATA_WIDTH-1:0] CLK_DIV_VAL  = 'd868,
  parameter logic [DATA_WIDTH-1:0] CFG_VAL      = 'h0
) (
  input  logic             clk_i,
  input  logic             arst_ni,
  input  logic             restart_i,
  uart_boot_ctrl_if.slave  bus,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  typedef enum logic [2:0] {
    ST_WAIT, ST_W_DIV, ST_W_CFG, ST_W_FLUSH, ST_W_CTRL, ST_DONE, ST_ERR
`ifdef UART_BOOT_VERIFY_EN
    , ST_VERIFY
`endif
  } state_e;

  state_e                  state_q, state_d, step_nxt;
  logic [7:0]              dly_q, dly_d;
  logic [3:0]              rty_q, rty_d;
  logic                    seq_we, seq_re, attempt, ok, pass_thru;
  logic [MEM_SIZE-1:0]     seq_waddr, seq_raddr;
  logic [DATA_WIDTH-1:0]   seq_wdata;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= ST_WAIT;
      dly_q   <= '0;
      rty_q   <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      rty_q   <= rty_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    rty_d     = rty_q;
    step_nxt  = state_q;
    seq_we    = 1'b0;
    seq_re    = 1'b0;
    seq_waddr = '0;
    seq_raddr = '0;
    seq_wdata = '0;
    attempt   = 1'b0;
    ok        = 1'b0;
    pass_thru = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (START_DELAY == 0 || dly_q == 8'(START_DELAY - 1)) begin
          state_d = ST_W_DIV;
          dly_d   = '0;
        end else begin
          dly_d = dly_q + 8'd1;
        end
      end
      ST_W_DIV: begin
        seq_we = 1'b1; seq_waddr = CLK_DIV_ADDR; seq_wdata = CLK_DIV_VAL;
        attempt = 1'b1; ok = (bus.mem_wresp_i == 2'b00); step_nxt = ST_W_CFG;
      end
      ST_W_CFG: begin
        seq_we = 1'b1; seq_waddr = CFG_ADDR; seq_wdata = CFG_VAL;
        attempt = 1'b1; ok = (bus.mem_wresp_i == 2'b00); step_nxt = ST_W_FLUSH;
      end
      ST_W_FLUSH: begin
        // both FIFO flushes with the baud clock held off
        seq_we = 1'b1; seq_waddr = CTRL_ADDR; seq_wdata = DATA_WIDTH'(6);
        attempt = 1'b1; ok = (bus.mem_wresp_i == 2'b00); step_nxt = ST_W_FLUSH;
        step_nxt = ST_W_CTRL;
      end
      ST_W_CTRL: begin
        seq_we = 1'b1; seq_waddr = CTRL_ADDR; seq_wdata = DATA_WIDTH'(1);
        attempt = 1'b1; ok = (bus.mem_wresp_i == 2'b00);
`ifdef UART_BOOT_VERIFY_EN
        step_nxt = ST_VERIFY;
`else
        step_nxt = ST_DONE;
`endif
      end
`ifdef UART_BOOT_VERIFY_EN
      ST_VERIFY: begin
        seq_re = 1'b1; seq_raddr = CLK_DIV_ADDR;
        attempt = 1'b1;
        ok = (bus.mem_rresp_i == 2'b00) && (bus.mem_rdata_i == CLK_DIV_VAL);
        step_nxt = ST_DONE;
      end
`endif
      ST_DONE, ST_ERR: begin
        pass_thru = 1'b1;
        if (restart_i) begin
          state_d = ST_W_DIV;
          dly_d   = '0;
          rty_d   = '0;
        end
      end
      default: state_d = ST_WAIT;
    endcase

    if (attempt) begin
      if (ok) begin
        state_d = step_nxt;
        rty_d   = '0;
      end else begin
        rty_d = rty_q + 4'd1;
        if ((rty_q + 4'd1) >= 4'(MAX_RETRY)) state_d = ST_ERR;
      end
    end
  end

  // register port is owned by the host once the sequence has finished or aborted
  always_comb begin
    bus.mem_we_o    = seq_we;
    bus.mem_re_o    = seq_re;
    bus.mem_waddr_o = seq_waddr;
    bus.mem_raddr_o = seq_raddr;
    bus.mem_wdata_o = seq_wdata;
    bus.mem_wstrb_o = seq_we ? '1 : '0;
    bus.h_wresp_o   = 2'b10;
    bus.h_rresp_o   = 2'b10;
    bus.h_rdata_o   = '0;
    if (pass_thru) begin
      bus.mem_we_o    = bus.h_we_i;
      bus.mem_re_o    = bus.h_re_i;
      bus.mem_waddr_o = bus.h_waddr_i;
      bus.mem_raddr_o = bus.h_raddr_i;
      bus.mem_wdata_o = bus.h_wdata_i;
      bus.mem_wstrb_o = bus.h_wstrb_i;
      bus.h_wresp_o   = bus.mem_wresp_i;
      bus.h_rresp_o   = bus.mem_rresp_i;
      bus.h_rdata_o   = bus.mem_rdata_i;
    end
  end

  assign busy_o = (state_q != ST_DONE) && (state_q != ST_ERR);
  assign done_o = (state_q == ST_DONE);
  assign err_o  = (state_q == ST_ERR);

endmodule

// File: tb/tb_uart_boot_ctrl.sv
// Self-checking bench for uart_boot_ctrl: random response plans against a step-list model.
module tb_uart_boot_ctrl;
  localparam int MS = 6, DW = 32, SD = 16, MR = 3;
  localparam logic [31:0] DIV = 32'd868;
`ifdef UART_BOOT_VERIFY_EN
  localparam int NSTEP = 5;
`else
  localparam int NSTEP = 4;
`endif

  logic clk = 1'b0, arst_n = 1'b0, restart = 1'b0;
  logic busy, done, err;
  int   checks = 0, errors = 0;

  uart_boot_ctrl_if #(.MEM_SIZE(MS), .DATA_WIDTH(DW)) bus();

  uart_boot_ctrl #(.MEM_SIZE(MS), .DATA_WIDTH(DW), .START_DELAY(SD), .MAX_RETRY(MR)) dut (
    .clk_i(clk), .arst_ni(arst_n), .restart_i(restart), .bus(bus.slave),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct { bit we; logic [5:0] addr; logic [31:0] data; } acc_t;
  acc_t exp_q[$], obs_q[$];
  int   obs_cyc[$];
  int   plan[64];   // per access: 0 ok, 1 error response, 2 bad read data
  bit   exp_err;

  // Expected access list: each step repeats until it succeeds or MR attempts fail.
  function automatic void model();
    bit          sw[5];
    logic [5:0]  sa[5];
    logic [31:0] sdv[5];
    int k, rty;
    bit f;
    sw  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    sa  = '{6'h08, 6'h04, 6'h00, 6'h00, 6'h08};
    sdv = '{DIV, 32'h0, 32'h6, 32'h1, 32'h0};
    exp_q.delete();
    exp_err = 1'b0;
    k = 0;
    for (int s = 0; s < NSTEP; s++) begin
      rty = 0;
      while (1) begin
        exp_q.push_back('{sw[s], sa[s], sdv[s]});
        f = (plan[k] == 1) || (plan[k] == 2 && !sw[s]);
        k++;
        if (!f) break;
        rty++;
        if (rty == MR) begin
          exp_err = 1'b1;
          return;
        end
      end
    end
  endfunction

  task automatic drive_mem(input int code);
    bus.mem_wresp_i = (code == 1) ? 2'b10 : 2'b00;
    bus.mem_rresp_i = (code == 1) ? 2'b10 : 2'b00;
    bus.mem_rdata_i = (code == 2) ? DIV + 32'd1 + $urandom_range(0, 99) : DIV;
  endtask

  task automatic host_drive(input bit junk);
    bus.h_we_i = junk; bus.h_re_i = junk;
    bus.h_waddr_i = 6'h0C; bus.h_raddr_i = 6'h0C;
    bus.h_wdata_i = 32'hAB; bus.h_wstrb_i = 4'hF;
  endtask

  task automatic clear_plan();
    for (int i = 0; i < 64; i++) plan[i] = 0;
  endtask

  // Runs one sequence; cycle 1 is the cycle in progress when called.
  task automatic run_seq(input string name, input int first_cyc, input int restart_at, input bit junk);
    int idx = 0, end_c = 0;
    bit busy_bad = 0, lock_bad = 0, strb_bad = 0, ord_bad = 0;
    obs_q.delete(); obs_cyc.delete();
    model();
    host_drive(junk);
    for (int c = 1; c <= first_cyc + 60; c++) begin
      drive_mem(idx < 64 ? plan[idx] : 0);
      restart = (c == restart_at);
      #1;
      if (done || err) begin end_c = c; break; end
      if (!busy) busy_bad = 1;
      if (bus.h_wresp_o !== 2'b10 || bus.h_rresp_o !== 2'b10 || bus.h_rdata_o !== 32'h0) lock_bad = 1;
      if (bus.mem_we_o === 1'b1 || bus.mem_re_o === 1'b1) begin
        if (bus.mem_we_o === 1'b1 && bus.mem_re_o === 1'b1) strb_bad = 1;
        if (bus.mem_we_o === 1'b1 && bus.mem_wstrb_o !== 4'hF) strb_bad = 1;
        if (bus.mem_we_o === 1'b1) obs_q.push_back('{1'b1, bus.mem_waddr_o, bus.mem_wdata_o});
        else                       obs_q.push_back('{1'b0, bus.mem_raddr_o, 32'h0});
        obs_cyc.push_back(c);
        idx++;
      end
      @(negedge clk);
    end
    restart = 1'b0;
    host_drive(1'b0);
    checks++;
    if (end_c == 0) begin
      errors++; $display("FAIL %s timeout: no done/err within budget", name);
      return;
    end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL %s access count: got %0d want %0d", name, obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        if (obs_q[i].we !== exp_q[i].we || obs_q[i].addr !== exp_q[i].addr ||
            (exp_q[i].we && obs_q[i].data !== exp_q[i].data) || obs_cyc[i] !== first_cyc + i)
          ord_bad = 1;
      end
      if (ord_bad) begin
        errors++;
        $display("FAIL %s access trace: first access cycle %0d want %0d", name, obs_cyc[0], first_cyc);
      end
    end
    checks++;
    if (end_c !== first_cyc + exp_q.size() || err !== exp_err || done !== !exp_err || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s end: cycle %0d done=%b err=%b busy=%b want cycle %0d err=%b",
               name, end_c, done, err, busy, first_cyc + exp_q.size(), exp_err);
    end
    checks++;
    if (busy_bad || lock_bad || strb_bad) begin
      errors++; $display("FAIL %s busy/lock/strb: busy_bad=%b lock_bad=%b strb_bad=%b want 000",
                         name, busy_bad, lock_bad, strb_bad);
    end
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    host_drive(1'b1);
    drive_mem(0);
    #1;
    checks++;
    if ({busy, done, err, bus.mem_we_o, bus.mem_re_o, bus.h_wresp_o, bus.h_rresp_o} !== 9'b100_00_10_10) begin
      errors++;
      $display("FAIL reset outputs: busy=%b done=%b err=%b we=%b re=%b wresp=%b rresp=%b want 1 0 0 0 0 10 10",
               busy, done, err, bus.mem_we_o, bus.mem_re_o, bus.h_wresp_o, bus.h_rresp_o);
    end
    host_drive(1'b0);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
  endtask

  task automatic test_nominal();
    clear_plan();
    run_seq("nominal", SD + 1, -1, 1'b0);
  endtask

  task automatic test_passthru(input string name);
    logic [1+1+6+6+32+4-1:0] hexp;
    logic [2+2+32-1:0]       rexp;
    for (int i = 0; i < 4; i++) begin
      bus.h_we_i = 1'($urandom); bus.h_re_i = 1'($urandom);
      bus.h_waddr_i = 6'($urandom); bus.h_raddr_i = 6'($urandom);
      bus.h_wdata_i = $urandom; bus.h_wstrb_i = 4'($urandom);
      bus.mem_wresp_i = 2'($urandom); bus.mem_rresp_i = 2'($urandom); bus.mem_rdata_i = $urandom;
      hexp = {bus.h_we_i, bus.h_re_i, bus.h_waddr_i, bus.h_raddr_i, bus.h_wdata_i, bus.h_wstrb_i};
      rexp = {bus.mem_wresp_i, bus.mem_rresp_i, bus.mem_rdata_i};
      #1;
      checks++;
      if ({bus.mem_we_o, bus.mem_re_o, bus.mem_waddr_o, bus.mem_raddr_o, bus.mem_wdata_o, bus.mem_wstrb_o} !== hexp ||
          {bus.h_wresp_o, bus.h_rresp_o, bus.h_rdata_o} !== rexp) begin
        errors++;
        $display("FAIL %s passthru: mem side %h resp side %h want %h %h", name,
                 {bus.mem_we_o, bus.mem_re_o, bus.mem_waddr_o, bus.mem_raddr_o, bus.mem_wdata_o, bus.mem_wstrb_o},
                 {bus.h_wresp_o, bus.h_rresp_o, bus.h_rdata_o}, hexp, rexp);
      end
      @(negedge clk);
    end
    host_drive(1'b0);
    drive_mem(0);
  endtask

  task automatic test_restart();
    host_drive(1'b1);
    bus.h_re_i = 1'b0;
    restart = 1'b1;
    #1;
    checks++;
    if (bus.mem_we_o !== 1'b1 || bus.mem_waddr_o !== 6'h0C || bus.mem_wdata_o !== 32'hAB) begin
      errors++; $display("FAIL restart forward: we=%b addr=%h data=%h want 1 0c ab",
                         bus.mem_we_o, bus.mem_waddr_o, bus.mem_wdata_o);
    end
    @(negedge clk);
    restart = 1'b0;
    host_drive(1'b0);
    clear_plan();
    run_seq("restart_wcfg_ignored", 1, 2, 1'b0);
  endtask

  task automatic test_retry_cfg();
    clear_plan();
    plan[1] = 1; plan[2] = 1;
    do_restart();
    run_seq("retry_cfg", 1, -1, 1'b0);
  endtask

  task automatic test_host_lock();
    arst_n = 1'b0; #1;
    @(negedge clk);
    arst_n = 1'b1;
    clear_plan();
    run_seq("host_lock", SD + 1, -1, 1'b1);
    host_drive(1'b1);
    bus.h_re_i = 1'b0;
    bus.mem_wresp_i = 2'b01;
    #1;
    checks++;
    if (bus.mem_we_o !== 1'b1 || bus.mem_waddr_o !== 6'h0C || bus.mem_wdata_o !== 32'hAB || bus.h_wresp_o !== 2'b01) begin
      errors++; $display("FAIL host_fwd: we=%b addr=%h data=%h wresp=%b want 1 0c ab 01",
                         bus.mem_we_o, bus.mem_waddr_o, bus.mem_wdata_o, bus.h_wresp_o);
    end
    host_drive(1'b0);
    drive_mem(0);
    @(negedge clk);
  endtask

  task automatic test_err();
    clear_plan();
    plan[0] = 1; plan[1] = 1; plan[2] = 1;
    do_restart();
    run_seq("err_wdiv", 1, -1, 1'b0);
    test_passthru("err");
  endtask

  task automatic test_reset_mid();
    arst_n = 1'b0; #1;
    @(negedge clk);
    arst_n = 1'b1;
    host_drive(1'b1);
    for (int c = 1; c <= SD + 3; c++) begin
      drive_mem(0);
      #1;
      if (c != SD + 3) @(negedge clk);
    end
    checks++;
    if (bus.mem_we_o !== 1'b1 || bus.mem_waddr_o !== 6'h00 || bus.mem_wdata_o !== 32'h6) begin
      errors++; $display("FAIL mid_flush: we=%b addr=%h data=%h want 1 00 6",
                         bus.mem_we_o, bus.mem_waddr_o, bus.mem_wdata_o);
    end
    arst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, err, bus.mem_we_o, bus.mem_re_o, bus.h_wresp_o} !== 7'b100_00_10) begin
      errors++; $display("FAIL mid_reset: busy=%b done=%b err=%b we=%b re=%b wresp=%b want 1 0 0 0 0 10",
                         busy, done, err, bus.mem_we_o, bus.mem_re_o, bus.h_wresp_o);
    end
    host_drive(1'b0);
    @(negedge clk);
    arst_n = 1'b1;
    clear_plan();
    run_seq("after_mid_reset", SD + 1, -1, 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      for (int i = 0; i < 64; i++)
        plan[i] = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 2)) : 0;
      do_restart();
      run_seq($sformatf("random%0d", it), 1, -1, 1'(it & 1));
    end
  endtask

  initial begin
    host_drive(1'b0);
    drive_mem(0);
    test_reset();
    test_nominal();
    test_passthru("done");
    test_restart();
    test_retry_cfg();
    test_host_lock();
    test_err();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
